// File: rtl/mac_phase_sequencer.sv
// mac_phase_sequencer
// Steps the shared MAC datapath through NUM_PHASES accumulation phases of
// PHASE_LEN beats, waits out the MAC pipeline after each phase, then writes
// the phase result to the result buffer over a valid/ready handshake.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | waiting for start; phase and addr parked at 0
//   S_RUN   | issuing MAC beats at addr; a stall holds everything
//   S_DRAIN | waiting MAC_LAT cycles for the accumulator to settle
//   S_WRITE | res_we held with res_idx=phase until res_ready
//   S_DONE  | one-cycle done pulse, then back to idle
module mac_phase_sequencer #(
  parameter int NUM_PHASES = 4,
  parameter int PHASE_LEN  = 36,
  parameter int MAC_LAT    = 3,
  parameter int PH_W       = (NUM_PHASES > 1) ? $clog2(NUM_PHASES) : 1,
  parameter int ADDR_W     = (PHASE_LEN > 1) ? $clog2(PHASE_LEN) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              stall,
  input  logic              res_ready,
  output logic              busy,
  output logic [PH_W-1:0]   phase,
  output logic [ADDR_W-1:0] addr,
  output logic              mac_en,
  output logic              acc_clr,
  output logic              res_we,
  output logic [PH_W-1:0]   res_idx,
  output logic              done
);

  // Drain counter is sized to hold MAC_LAT; kept at one bit when unused.
  localparam int DR_W = (MAC_LAT > 0) ? $clog2(MAC_LAT + 1) : 1;

  localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(NUM_PHASES - 1);
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(PHASE_LEN - 1);
  localparam logic [DR_W-1:0]   DR_LOAD   = DR_W'(MAC_LAT);
  localparam logic [DR_W-1:0]   DR_ONE    = DR_W'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RUN   = 3'd1,
    S_DRAIN = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t            state, state_n;
  logic [PH_W-1:0]   phase_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DR_W-1:0]   drain_cnt, drain_cnt_n;

  // State and counter registers; reset aborts any job in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      phase     <= '0;
      addr      <= '0;
      drain_cnt <= '0;
    end else begin
      state     <= state_n;
      phase     <= phase_n;
      addr      <= addr_n;
      drain_cnt <= drain_cnt_n;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_n     = state;
    phase_n     = phase;
    addr_n      = addr;
    drain_cnt_n = drain_cnt;
    case (state)
      S_IDLE: begin
        if (start) begin
          state_n = S_RUN;
          phase_n = '0;
          addr_n  = '0;
        end
      end
      S_RUN: begin
        if (!stall) begin
          if (addr == ADDR_LAST) begin
            addr_n = '0;
            // With no MAC latency the result is already valid, skip DRAIN.
            if (MAC_LAT == 0) begin
              state_n = S_WRITE;
            end else begin
              state_n     = S_DRAIN;
              drain_cnt_n = DR_LOAD;
            end
          end else begin
            addr_n = addr + 1'b1;
          end
        end
      end
      S_DRAIN: begin
        drain_cnt_n = drain_cnt - 1'b1;
        if (drain_cnt == DR_ONE) begin
          state_n = S_WRITE;
        end
      end
      S_WRITE: begin
        if (res_ready) begin
          if (phase == PH_LAST) begin
            state_n = S_DONE;
          end else begin
            phase_n = phase + 1'b1;
            state_n = S_RUN;
          end
        end
      end
      S_DONE: begin
        state_n = S_IDLE;
        phase_n = '0;
        addr_n  = '0;
      end
      default: begin
        state_n = S_IDLE;
        phase_n = '0;
        addr_n  = '0;
      end
    endcase
  end

  // Output decode; only mac_en/acc_clr see an input (stall) combinationally.
  always_comb begin
    busy    = (state != S_IDLE);
    mac_en  = (state == S_RUN) && !stall;
    acc_clr = (state == S_RUN) && !stall && (addr == '0);
    res_we  = (state == S_WRITE);
    res_idx = phase;
    done    = (state == S_DONE);
  end

endmodule

// File: tb/tb_mac_phase_sequencer.sv
// Directed bench for mac_phase_sequencer: default configuration plus a
// single-beat, zero-latency, single-phase instance sharing the same stimulus.
// Cycle 0 of every scenario is the cycle in which the first start is driven.
module tb_mac_phase_sequencer;

  localparam int N = 180;

  logic       clk = 1'b0;
  logic       reset, start, stall, res_ready;
  logic       busy, mac_en, acc_clr, res_we, done;
  logic [1:0] phase, res_idx;
  logic [5:0] addr;
  logic       busy1, mac_en1, acc_clr1, res_we1, done1;
  logic [0:0] phase1, res_idx1, addr1;

  int errors = 0;
  int checks = 0;

  logic       rst_v[N], start_v[N], stall_v[N], ready_v[N];
  logic       t_busy[N], t_mac[N], t_acc[N], t_we[N], t_done[N];
  logic [1:0] t_ph[N], t_idx[N];
  logic [5:0] t_addr[N];
  logic       t1_busy[N], t1_mac[N], t1_acc[N], t1_we[N], t1_done[N];

  mac_phase_sequencer dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .res_ready(res_ready),
    .busy(busy), .phase(phase), .addr(addr), .mac_en(mac_en), .acc_clr(acc_clr),
    .res_we(res_we), .res_idx(res_idx), .done(done)
  );

  mac_phase_sequencer #(.NUM_PHASES(1), .PHASE_LEN(1), .MAC_LAT(0)) dut1 (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .res_ready(res_ready),
    .busy(busy1), .phase(phase1), .addr(addr1), .mac_en(mac_en1), .acc_clr(acc_clr1),
    .res_we(res_we1), .res_idx(res_idx1), .done(done1)
  );

  always #5 clk = ~clk;

  // Reset both DUTs and clear the stimulus vectors.
  task automatic prep();
    reset = 1'b1; start = 1'b0; stall = 1'b0; res_ready = 1'b1;
    for (int c = 0; c < N; c++) begin
      rst_v[c] = 1'b0; start_v[c] = 1'b0; stall_v[c] = 1'b0; ready_v[c] = 1'b1;
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Apply the vectors cycle by cycle and record outputs mid-cycle.
  task automatic simulate();
    for (int c = 0; c < N; c++) begin
      reset = rst_v[c]; start = start_v[c]; stall = stall_v[c]; res_ready = ready_v[c];
      #1;
      t_busy[c] = busy;  t_mac[c] = mac_en;  t_acc[c] = acc_clr;
      t_we[c]   = res_we; t_done[c] = done;  t_ph[c]  = phase;
      t_idx[c]  = res_idx; t_addr[c] = addr;
      t1_busy[c] = busy1; t1_mac[c] = mac_en1; t1_acc[c] = acc_clr1;
      t1_we[c]   = res_we1; t1_done[c] = done1;
      @(posedge clk);
      #1;
    end
    reset = 1'b0; start = 1'b0; stall = 1'b0; res_ready = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b1; stall = 1'b0; res_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({busy, mac_en, acc_clr, res_we, done, phase, addr, res_idx} !== 15'd0) begin
      errors++;
      $display("FAIL reset_outputs: got busy=%b mac_en=%b acc_clr=%b res_we=%b done=%b phase=%0d addr=%0d res_idx=%0d, want all 0",
               busy, mac_en, acc_clr, res_we, done, phase, addr, res_idx);
    end
    checks++;
    if ({busy1, mac_en1, acc_clr1, res_we1, done1} !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs_small: got %b, want 00000",
               {busy1, mac_en1, acc_clr1, res_we1, done1});
    end
  endtask

  task automatic test_nominal();
    int bad_mac, bad_acc, bad_we, bad_done, bad_busy, bad_addr, first;
    logic e;
    prep();
    start_v[0] = 1'b1;
    simulate();
    bad_mac = 0; bad_acc = 0; bad_we = 0; bad_done = 0; bad_busy = 0; bad_addr = 0; first = -1;
    for (int c = 0; c < N; c++) begin
      e = (c >= 1 && c <= 36) || (c >= 41 && c <= 76) || (c >= 81 && c <= 116) || (c >= 121 && c <= 156);
      if (t_mac[c] !== e) begin bad_mac++; if (first < 0) first = c; end
      if (e && t_addr[c] !== 6'((c - 1) % 40)) bad_addr++;
      e = (c == 1) || (c == 41) || (c == 81) || (c == 121);
      if (t_acc[c] !== e) bad_acc++;
      e = (c == 40) || (c == 80) || (c == 120) || (c == 160);
      if (t_we[c] !== e) bad_we++;
      if (e && t_idx[c] !== 2'((c / 40) - 1)) bad_we++;
      if (t_done[c] !== (c == 161)) bad_done++;
      if (t_busy[c] !== (c >= 1 && c <= 161)) bad_busy++;
    end
    checks++;
    if (bad_mac != 0) begin errors++; $display("FAIL nom_mac_en: %0d cycles wrong, first at %0d, want 1-36/41-76/81-116/121-156", bad_mac, first); end
    checks++;
    if (bad_addr != 0) begin errors++; $display("FAIL nom_addr: %0d beats with wrong addr, want (cycle-1) mod 40", bad_addr); end
    checks++;
    if (bad_acc != 0) begin errors++; $display("FAIL nom_acc_clr: %0d cycles wrong, want high at 1,41,81,121", bad_acc); end
    checks++;
    if (bad_we != 0) begin errors++; $display("FAIL nom_res_we: %0d cycles wrong, want 40,80,120,160 idx 0..3", bad_we); end
    checks++;
    if (bad_done != 0) begin errors++; $display("FAIL nom_done: %0d cycles wrong, want cycle 161 only", bad_done); end
    checks++;
    if (bad_busy != 0) begin errors++; $display("FAIL nom_busy: %0d cycles wrong, want 1-161", bad_busy); end
    // Single-beat instance saw the same start at cycle 0.
    bad_mac = 0;
    for (int c = 0; c < 20; c++) begin
      if (t1_mac[c] !== (c == 1)) bad_mac++;
      if (t1_acc[c] !== (c == 1)) bad_mac++;
      if (t1_we[c] !== (c == 2)) bad_mac++;
      if (t1_done[c] !== (c == 3)) bad_mac++;
      if (t1_busy[c] !== (c >= 1 && c <= 3)) bad_mac++;
    end
    checks++;
    if (bad_mac != 0) begin errors++; $display("FAIL boundary_len1_lat0: %0d samples wrong, want mac/acc@1 we@2 done@3", bad_mac); end
  endtask

  task automatic test_stall();
    int bad_hold, nbeat, bad_seq, bad_done;
    prep();
    start_v[0] = 1'b1;
    for (int c = 11; c <= 15; c++) stall_v[c] = 1'b1;
    stall_v[41] = 1'b1; stall_v[42] = 1'b1;
    simulate();
    bad_hold = 0;
    for (int c = 11; c <= 15; c++) if (t_mac[c] !== 1'b0 || t_addr[c] !== 6'd10) bad_hold++;
    for (int c = 41; c <= 42; c++) if (t_mac[c] !== 1'b0 || t_addr[c] !== 6'd35) bad_hold++;
    checks++;
    if (bad_hold != 0) begin errors++; $display("FAIL stall_hold: %0d stall cycles with mac_en or addr wrong, want mac_en=0 addr=10/35", bad_hold); end
    nbeat = 0; bad_seq = 0;
    for (int c = 0; c <= 46; c++) begin
      if (t_mac[c] === 1'b1) begin
        if (t_addr[c] !== 6'(nbeat)) bad_seq++;
        nbeat++;
      end
    end
    checks++;
    if (nbeat != 36 || bad_seq != 0) begin errors++; $display("FAIL stall_addr_seq: %0d beats, %0d out of order, want 36 beats 0..35", nbeat, bad_seq); end
    checks++;
    if (t_mac[43] !== 1'b1 || t_addr[43] !== 6'd35) begin errors++; $display("FAIL stall_last_beat: mac_en=%b addr=%0d at 43, want 1/35", t_mac[43], t_addr[43]); end
    bad_done = 0;
    for (int c = 0; c < N; c++) if (t_done[c] !== (c == 168)) bad_done++;
    checks++;
    if (bad_done != 0) begin errors++; $display("FAIL stall_done: %0d cycles wrong, want cycle 168 only", bad_done); end
  endtask

  task automatic test_backpressure();
    int bad_we, hs, bad_done;
    prep();
    start_v[0] = 1'b1;
    for (int c = 120; c <= 123; c++) ready_v[c] = 1'b0;
    simulate();
    bad_we = 0;
    for (int c = 120; c <= 124; c++) if (t_we[c] !== 1'b1 || t_idx[c] !== 2'd2) bad_we++;
    checks++;
    if (bad_we != 0) begin errors++; $display("FAIL bp_we_stable: %0d cycles of 120-124 with res_we/res_idx wrong, want 1/2", bad_we); end
    hs = 0;
    for (int c = 0; c < N; c++) if (t_we[c] === 1'b1 && ready_v[c]) hs++;
    checks++;
    if (hs != 4) begin errors++; $display("FAIL bp_handshakes: got %0d writes, want 4", hs); end
    checks++;
    if (t_we[125] !== 1'b0 || t_mac[125] !== 1'b1 || t_acc[125] !== 1'b1 || t_ph[125] !== 2'd3) begin
      errors++;
      $display("FAIL bp_phase3_start: at 125 we=%b mac=%b acc=%b phase=%0d, want 0/1/1/3", t_we[125], t_mac[125], t_acc[125], t_ph[125]);
    end
    bad_done = 0;
    for (int c = 0; c < N; c++) if (t_done[c] !== (c == 165)) bad_done++;
    checks++;
    if (bad_done != 0) begin errors++; $display("FAIL bp_done: %0d cycles wrong, want cycle 165 only", bad_done); end
  endtask

  task automatic test_ignored_start();
    int nmac, bad;
    prep();
    start_v[0] = 1'b1; start_v[50] = 1'b1;
    simulate();
    nmac = 0; bad = 0;
    for (int c = 0; c < N; c++) begin
      if (t_mac[c] === 1'b1) nmac++;
      if (t_done[c] !== (c == 161)) bad++;
      if (c >= 162 && t_busy[c] !== 1'b0) bad++;
    end
    checks++;
    if (nmac != 144 || bad != 0) begin errors++; $display("FAIL ignored_start: %0d beats, %0d bad done/busy samples, want 144 and 0", nmac, bad); end
  endtask

  task automatic test_back_to_back();
    prep();
    for (int c = 0; c < N; c++) start_v[c] = 1'b1;
    simulate();
    checks++;
    if (t_done[161] !== 1'b1 || t_done[160] !== 1'b0) begin errors++; $display("FAIL b2b_done: done@160=%b done@161=%b, want 0/1", t_done[160], t_done[161]); end
    checks++;
    if (t_busy[162] !== 1'b0 || t_mac[162] !== 1'b0) begin errors++; $display("FAIL b2b_idle: busy=%b mac_en=%b at 162, want 0/0", t_busy[162], t_mac[162]); end
    checks++;
    if (t_mac[163] !== 1'b1 || t_acc[163] !== 1'b1 || t_addr[163] !== 6'd0 || t_ph[163] !== 2'd0) begin
      errors++;
      $display("FAIL b2b_restart: at 163 mac=%b acc=%b addr=%0d phase=%0d, want 1/1/0/0", t_mac[163], t_acc[163], t_addr[163], t_ph[163]);
    end
  endtask

  task automatic test_reset_mid_job();
    int bad;
    prep();
    start_v[0] = 1'b1;
    rst_v[90]  = 1'b1;
    simulate();
    checks++;
    if (t_mac[90] !== 1'b1 || t_addr[90] !== 6'd9 || t_ph[90] !== 2'd2) begin
      errors++;
      $display("FAIL rst_pre: at 90 mac=%b addr=%0d phase=%0d, want 1/9/2", t_mac[90], t_addr[90], t_ph[90]);
    end
    checks++;
    if ({t_busy[91], t_mac[91], t_acc[91], t_we[91], t_done[91], t_ph[91], t_addr[91], t_idx[91]} !== 15'd0) begin
      errors++;
      $display("FAIL rst_mid_outputs: busy=%b mac=%b acc=%b we=%b done=%b phase=%0d addr=%0d idx=%0d at 91, want all 0",
               t_busy[91], t_mac[91], t_acc[91], t_we[91], t_done[91], t_ph[91], t_addr[91], t_idx[91]);
    end
    bad = 0;
    for (int c = 91; c < N; c++) if (t_we[c] !== 1'b0 || t_done[c] !== 1'b0 || t_busy[c] !== 1'b0) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL rst_mid_quiet: %0d cycles after reset with activity, want 0", bad); end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_stall();
    test_backpressure();
    test_ignored_start();
    test_back_to_back();
    test_reset_mid_job();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
